// File: rtl/universal_shift_register_n_bit_if.sv
// Signal bundle for the universal shift register: control and data inputs
// driven by the master, register state and status returned by the slave.
interface universal_shift_register_n_bit_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
);
    logic             Enable_In;
    logic [2:0]       Mode_In;
    logic             Serial_Data_MSB_In;
    logic             Serial_Data_LSB_In;
    logic [WIDTH-1:0] Parallel_Data_In;
    logic [WIDTH-1:0] Parallel_Data_Out;
    logic             Serial_Data_LSB_Out;
    logic             Serial_Data_MSB_Out;
    logic [CNT_W-1:0] Shift_Count_Out;
    logic             Word_Done_Out;

    modport master (
        output Enable_In,
        output Mode_In,
        output Serial_Data_MSB_In,
        output Serial_Data_LSB_In,
        output Parallel_Data_In,
        input  Parallel_Data_Out,
        input  Serial_Data_LSB_Out,
        input  Serial_Data_MSB_Out,
        input  Shift_Count_Out,
        input  Word_Done_Out
    );

    modport slave (
        input  Enable_In,
        input  Mode_In,
        input  Serial_Data_MSB_In,
        input  Serial_Data_LSB_In,
        input  Parallel_Data_In,
        output Parallel_Data_Out,
        output Serial_Data_LSB_Out,
        output Serial_Data_MSB_Out,
        output Shift_Count_Out,
        output Word_Done_Out
    );
endinterface

// File: rtl/universal_shift_register_n_bit.sv
// WIDTH-bit universal shift register (hold/shift/rotate/load/clear) updated on
// the falling clock edge, with a word counter that pulses once per WIDTH shifts.
module universal_shift_register_n_bit #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
    parameter int               CNT_W       = $clog2(WIDTH)
) (
    input  logic                              Clk_In,
    input  logic                              Reset_In,
    universal_shift_register_n_bit_if.slave   bus_if
);

    localparam logic [2:0] MODE_HOLD     = 3'b000;
    localparam logic [2:0] MODE_SHR      = 3'b001;
    localparam logic [2:0] MODE_SHL      = 3'b010;
    localparam logic [2:0] MODE_ROR      = 3'b011;
    localparam logic [2:0] MODE_ROL      = 3'b100;
    localparam logic [2:0] MODE_LOAD     = 3'b101;
    localparam logic [2:0] MODE_CLEAR    = 3'b110;
    localparam logic [2:0] MODE_RESERVED = 3'b111;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_count;
    logic             r_word_done;

    logic [WIDTH-1:0] w_next_data;
    logic             w_shift_op;
    logic             w_restart;
    logic [CNT_W-1:0] w_next_count;
    logic             w_next_done;

    // Register data path and classification of the sampled operation.
    always_comb begin
        w_next_data = r_data;
        w_shift_op  = 1'b0;
        w_restart   = 1'b0;
        if (bus_if.Enable_In) begin
            case (bus_if.Mode_In)
                MODE_HOLD: begin
                    w_next_data = r_data;
                end
                MODE_SHR: begin
                    w_next_data = {bus_if.Serial_Data_MSB_In, r_data[WIDTH-1:1]};
                    w_shift_op  = 1'b1;
                end
                MODE_SHL: begin
                    w_next_data = {r_data[WIDTH-2:0], bus_if.Serial_Data_LSB_In};
                    w_shift_op  = 1'b1;
                end
                MODE_ROR: begin
                    w_next_data = {r_data[0], r_data[WIDTH-1:1]};
                    w_shift_op  = 1'b1;
                end
                MODE_ROL: begin
                    w_next_data = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
                    w_shift_op  = 1'b1;
                end
                MODE_LOAD: begin
                    w_next_data = bus_if.Parallel_Data_In;
                    w_restart   = 1'b1;
                end
                // Clear is to zero, deliberately independent of RESET_VALUE.
                MODE_CLEAR: begin
                    w_next_data = {WIDTH{1'b0}};
                    w_restart   = 1'b1;
                end
                MODE_RESERVED: begin
                    w_next_data = r_data;
                end
                default: begin
                    w_next_data = r_data;
                end
            endcase
        end else begin
            w_next_data = r_data;
        end
    end

    // Word counter: wraps at WIDTH-1 and raises the done pulse for that cycle.
    always_comb begin
        w_next_count = r_count;
        w_next_done  = 1'b0;
        if (w_restart) begin
            w_next_count = ZERO_CNT;
            w_next_done  = 1'b0;
        end else if (w_shift_op) begin
            if (r_count == LAST_CNT) begin
                w_next_count = ZERO_CNT;
                w_next_done  = 1'b1;
            end else begin
                w_next_count = r_count + ONE_CNT;
                w_next_done  = 1'b0;
            end
        end else begin
            w_next_count = r_count;
            w_next_done  = 1'b0;
        end
    end

    // State registers, falling-edge clocked with asynchronous active-high reset.
    always_ff @(negedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            r_data      <= RESET_VALUE;
            r_count     <= ZERO_CNT;
            r_word_done <= 1'b0;
        end else begin
            r_data      <= w_next_data;
            r_count     <= w_next_count;
            r_word_done <= w_next_done;
        end
    end

    assign bus_if.Parallel_Data_Out   = r_data;
    assign bus_if.Serial_Data_LSB_Out = r_data[0];
    assign bus_if.Serial_Data_MSB_Out = r_data[WIDTH-1];
    assign bus_if.Shift_Count_Out     = r_count;
    assign bus_if.Word_Done_Out       = r_word_done;

endmodule

// File: doc/universal_shift_register_n_bit.md
# universal_shift_register_n_bit

Parametrised universal shift register, the generalised successor to the team's fixed 8-bit serial-in/serial-out register. It supports hold, bidirectional shift, bidirectional rotate, parallel load and synchronous clear on a WIDTH-bit register. A shift counter flags each completed word of WIDTH shift/rotate operations, so the block can act as a serialiser or deserialiser front end inside serial links and test fixtures.

## Interface
- WIDTH, 8, register width in bits; legal range 2..64.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into the register on reset.
- CNT_W, $clog2(WIDTH), derived width of the shift counter; not overridden by users.

- Clk_In  input  1  clock; all state updates on the falling edge.
- Reset_In  input  1  reset; asynchronous, active-high.
- Enable_In  input  1  operation enable; low means hold everything (register, counter, done flag cleared).
- Mode_In  input  3  operation select (see Operation).
- Serial_Data_MSB_In  input  1  bit entering at bit WIDTH-1 on a shift toward LSB.
- Serial_Data_LSB_In  input  1  bit entering at bit 0 on a shift toward MSB.
- Parallel_Data_In  input  WIDTH  word captured on parallel load.
- Parallel_Data_Out  output  WIDTH  current register contents.
- Serial_Data_LSB_Out  output  1  combinational copy of register bit 0.
- Serial_Data_MSB_Out  output  1  combinational copy of register bit WIDTH-1.
- Shift_Count_Out  output  CNT_W  shift/rotate operations since the last word boundary, load or clear; range 0..WIDTH-1.
- Word_Done_Out  output  1  registered one-cycle pulse marking completion of WIDTH shift/rotate operations.

## Operation
- Mode encoding, applied only when Enable_In=1:
  - 000: hold.
  - 001: shift toward LSB. reg <= {Serial_Data_MSB_In, reg[WIDTH-1:1]}.
  - 010: shift toward MSB. reg <= {reg[WIDTH-2:0], Serial_Data_LSB_In}.
  - 011: rotate toward LSB. reg <= {reg[0], reg[WIDTH-1:1]}.
  - 100: rotate toward MSB. reg <= {reg[WIDTH-2:0], reg[WIDTH-1]}.
  - 101: parallel load. reg <= Parallel_Data_In.
  - 110: synchronous clear. reg <= 0. This is zero, not RESET_VALUE.
  - 111: reserved; behaves as hold.
- Counter rules:
  - Modes 001-100 increment Shift_Count_Out.
  - When the count is WIDTH-1, the increment wraps it to 0 and sets Word_Done_Out for that cycle.
  - Modes 101 and 110 force the count to 0 and Word_Done_Out to 0.
  - Hold modes, and any cycle with Enable_In=0, leave the count unchanged and drive Word_Done_Out to 0.
- Word_Done_Out is high only in the cycle following the edge that completed the word. It never stays high for two consecutive cycles unless back-to-back words complete, which requires WIDTH shifts between pulses.
- Mode_In and serial/parallel inputs are sampled only at the falling edge. Changing Mode_In mid-word does not reset the count; shifts and rotates of either direction accumulate into the same count.

## Timing
- On reset assertion, with no clock required:
  - Parallel_Data_Out = RESET_VALUE.
  - Serial outputs = RESET_VALUE[0] and RESET_VALUE[WIDTH-1].
  - Shift_Count_Out = 0, Word_Done_Out = 0.
  - Reset dominates every other input while high.
- Reset deassertion: the first update occurs on the first falling edge after Reset_In goes low.
- Register latency: 1 edge from sampled mode to updated Parallel_Data_Out.
- Serial output latency: serial outputs follow the register combinationally, so the bit leaving on a shift toward LSB is visible on Serial_Data_LSB_Out before that edge.
- Word_Done_Out is registered, asserted from the completing falling edge to the next falling edge.
- Reset asserted mid-word: partial count is discarded, and the pending done pulse is cleared immediately.
- Enable_In low on the completing edge: no wrap, no pulse; the word completes on the next enabled shift.

## Test plan
- **Async reset mid-operation.** WIDTH=8, RESET_VALUE=8'h3C; load 8'hA5, perform 3 shifts, then pulse Reset_In between clock edges. Required: Parallel_Data_Out=8'h3C, count=0, Word_Done_Out=0 immediately, with no clock edge.
- **Load then shift toward LSB.** Load 8'hA5, then 8 edges of mode 001 with Serial_Data_MSB_In=0. Required:
  - Serial_Data_LSB_Out before each edge reads 1,0,1,0,0,1,0,1.
  - Final register = 8'h00.
  - Word_Done_Out high exactly one cycle after the 8th edge; count returns to 0.
- **Rotate toward MSB.** Load 8'h81, rotate toward MSB once. Required: 8'h03. Continue to 8 total rotates. Required: 8'h81 and one Word_Done_Out pulse.
- **Shift toward MSB with enable gating.** Clear, then 3 edges of mode 010 with Serial_Data_LSB_In=1. Required: 8'h07, count=3. Then Enable_In=0 with mode 001 for 4 edges. Required: 8'h07, count=3, no pulse.
- **Clear mid-word.** After 5 shifts, apply mode 110. Required: 8'h00, count=0. Then 8 shifts. Required: Word_Done_Out pulses only after the 8th.
- **Reserved mode and mixed-direction accumulation.**
  - Mode 111 for 2 edges. Required: register and count unchanged.
  - From a cleared state, 4 shifts toward LSB then 4 rotates toward MSB. Required: Word_Done_Out pulse on the 8th operation.
